// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU controller and its 1-bit slice.
package alu_pkg;

   // Low two bits of the op field select the slice function.
   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   // Full 4-bit encodings: bit 3 inverts A, bit 2 inverts B and seeds carry-in.
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

   function automatic logic op_is_legal(input logic [3:0] op);
      return op[1:0] != OP_ILL;
   endfunction

endpackage

// File: rtl/alu_serial_slice.sv
// 1-bit ALU slice: AND / OR / full-add with optional inversion of either input.
// cout is only meaningful for ADD; the controller masks it for logic ops.
module alu_serial_slice
   import alu_pkg::*;
(
   input  logic       a_bit,
   input  logic       b_bit,
   input  logic       cin,
   input  logic [3:0] op,
   output logic       res_bit,
   output logic       cout
);

   logic a_eff;
   logic b_eff;

   // Bit-level function select after input inversion.
   always_comb begin
      a_eff   = a_bit ^ op[3];
      b_eff   = b_bit ^ op[2];
      res_bit = 1'b0;
      cout    = 1'b0;
      case (op[1:0])
         OP_AND: res_bit = a_eff & b_eff;
         OP_OR:  res_bit = a_eff | b_eff;
         OP_ADD: begin
            res_bit = a_eff ^ b_eff ^ cin;
            cout    = (a_eff & b_eff) | (cin & (a_eff ^ b_eff));
         end
         default: begin
            res_bit = 1'b0;
            cout    = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial WIDTH-bit ALU controller: steps one 1-bit slice LSB-first,
// threading the carry, and reports result and flags with start/done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; illegal op pulses op_err, stays here
// RUN     | one operand bit per clock, cnt counts 0..WIDTH-1
// DONE    | done pulse, result and flags valid; back to IDLE next edge
module alu_serial_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             op_err
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   alu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [3:0]       op_q, op_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_out_q, carry_out_d;
   logic             overflow_q, overflow_d;
   logic             zero_q, zero_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             op_err_q, op_err_d;

   logic             slice_res;
   logic             slice_cout;
   logic             is_add;

   alu_serial_slice u_slice (
      .a_bit   (a_sh_q[0]),
      .b_bit   (b_sh_q[0]),
      .cin     (carry_q),
      .op      (op_q),
      .res_bit (slice_res),
      .cout    (slice_cout)
   );

   assign is_add = (op_q[1:0] == OP_ADD);

   // Next-state, datapath shifting and flag capture.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      op_d        = op_q;
      carry_d     = carry_q;
      result_d    = result_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;
      zero_d      = zero_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      op_err_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (op_is_legal(op)) begin
                  a_sh_d  = a;
                  b_sh_d  = b;
                  op_d    = op;
                  // Inverting B with carry-in 1 turns ADD into two's-complement SUB.
                  carry_d = op[2];
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  state_d = ST_RUN;
               end else begin
                  op_err_d = 1'b1;
               end
            end
         end

         ST_RUN: begin
            result_d = {slice_res, result_q[WIDTH-1:1]};
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            carry_d  = slice_cout;
            if (cnt_q == CNT_LAST) begin
               // carry_q here is the carry into the MSB, needed for signed overflow.
               carry_out_d = is_add & slice_cout;
               overflow_d  = is_add & (carry_q ^ slice_cout);
               zero_d      = (result_d == '0);
               done_d      = 1'b1;
               state_d     = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_DONE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         op_q        <= '0;
         carry_q     <= 1'b0;
         result_q    <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         zero_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         op_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         op_q        <= op_d;
         carry_q     <= carry_d;
         result_q    <= result_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
         zero_q      <= zero_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         op_err_q    <= op_err_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;
   assign zero      = zero_q;
   assign op_err    = op_err_q;

endmodule

// File: doc/alu_serial_ctrl.md
# alu_serial_ctrl

Bit-serial N-bit ALU controller built around a single 1-bit ALU slice. It accepts a WIDTH-bit operation request and steps the slice LSB-first, one bit per clock, threading the carry between bits. It reports the result, carry, overflow and zero flags with a start/done handshake. It sits between the datapath control and the register file wherever area matters more than latency.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request strobe, sampled only in IDLE
- op  in  4  ALU operation: [3] invert A, [2] invert B (also sets initial carry-in), [1:0] 00 AND, 01 OR, 10 ADD, 11 illegal
- a  in  WIDTH  operand A, latched at accept
- b  in  WIDTH  operand B, latched at accept
- busy  out  1  high from the accept edge until the cycle done is high, inclusive
- done  out  1  one-cycle pulse; result and flags valid
- result  out  WIDTH  result register; holds until the next accept
- carry_out  out  1  final carry for ADD ops, 0 for logic ops
- overflow  out  1  signed overflow for ADD ops (carry into MSB XOR carry out), 0 for logic ops
- zero  out  1  result == 0
- op_err  out  1  one-cycle pulse when start arrives with op[1:0]==11

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE + start + legal op:
  - latch a, b and op into shift registers.
  - carry ← op[2], so SUB = 0110 and NOR = 1100.
  - cnt ← 0, go to RUN.
- IDLE + start + illegal op: op_err = 1 next cycle; stay in IDLE; result and flags unchanged.
- RUN, each edge:
  - slice computes bit 0 of the A/B shift registers with the carry.
  - result shifts right with the slice output entering at the MSB.
  - A/B shift right; carry ← slice carry; cnt++.
  - At cnt == WIDTH-1, capture the carry into the MSB (for overflow), then go to DONE.
- DONE:
  - done = 1; carry_out, overflow and zero are registered.
  - Next edge returns to IDLE.
- start during RUN/DONE is ignored: no queueing, no op_err.
- Operand changes after accept have no effect.
- Logic ops still take WIDTH cycles; no early exit.
- Reset (any state, asynchronous): state IDLE, cnt 0, result 0, carry_out 0, overflow 0, zero 0, busy 0, done 0, op_err 0.

## Timing
- Accept edge E0; bit i is processed on edge E(i+1); DONE is entered at edge E(WIDTH).
- done is high in the cycle after E(WIDTH), i.e. WIDTH+1 edges after accept.
- A new start may be accepted in the cycle following done: back-to-back throughput is one op per WIDTH+2 cycles.
- busy is low in the cycle start is sampled and high from E0.
- op_err rises on the edge after the illegal start and lasts one cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- cnt width is $clog2(WIDTH); it never wraps past WIDTH-1.

## Structure
- Shared package alu_pkg:
  - op field constants: OP_AND=2'b00, OP_OR=2'b01, OP_ADD=2'b10.
  - full-op constants: ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_NOR=4'b1100.
  - FSM state enum.
- One sub-module, alu_serial_slice: combinational 1-bit AND/OR/ADD with input inversion.
  - inputs: a_bit, b_bit, cin, op.
  - outputs: res_bit, cout.
  - cout is valid for ADD only; the controller masks it for logic ops.
- Controller: FSM, counter, three shift registers, flag logic.

## Test plan
- WIDTH=8, ADD a=8'h7F b=8'h01 → done at accept+9 edges, result 8'h80, carry_out 0, overflow 1, zero 0.
- SUB (op 0110) a=8'h05 b=8'h05 → result 8'h00, carry_out 1, overflow 0, zero 1.
- NOR (op 1100) a=8'hF0 b=8'h0F → result 8'h00, zero 1; then OR a=8'hF0 b=8'h0F → result 8'hFF, carry_out 0.
- start with op=4'b0011 → op_err high for exactly one cycle, busy stays 0, result unchanged.
- start held high for 20 cycles with ADD 8'h01+8'h01 → first op yields 8'h02; second accept occurs one cycle after done; no op_err.
- rst_n low during RUN at bit 3 → all outputs 0 immediately; after release, ADD 8'hFF+8'h01 → result 8'h00, carry_out 1, zero 1.
